cpu_test_ctrl: RTL and testbench
================================

# cpu_test_ctrl

Synthesizable test sequencer for the RISC-I single-cycle CPU that replaces the fixed bench loader and scan loop. It:
- streams a program into instruction memory over a valid/ready port and zero-fills the unused tail;
- runs the CPU for a programmable cycle count;
- freezes the CPU and scans the register file, then data memory, through the CPU test port;
- compares each scanned word against a golden valid/ready stream and reports pass/fail, error count and first failing address.

It sits between the bench (or a host link) and the CPU's `i_Write_Instr` / `i_Reg_or_Data` / `i_Test_Addr` / `o_Test_Data` ports.

## Interface
Clock is `i_CLK`; reset is `i_RSTN`, asynchronous, active-low.

Parameters:
- `WORD_LEN`, 32: instruction and data word width.
- `IMEM_DEPTH`, 64: instruction memory words; `IA_W = $clog2(IMEM_DEPTH)`.
- `REG_SIZE`, 32: register file entries scanned.
- `DMEM_DEPTH`, 64: data memory words scanned; `TA_W = $clog2(max(REG_SIZE, DMEM_DEPTH))`.
- `SCAN_DMEM`, 1: 0 skips the data-memory scan.
- `CYC_W`, 16: run-cycle counter width.
- `ERR_W`, 8: error counter width; the counter saturates.

Ports:
- `i_CLK`, in, 1: clock.
- `i_RSTN`, in, 1: asynchronous active-low reset.
- `i_Start`, in, 1: start pulse; accepted only in IDLE or DONE.
- `i_Run_Cycles`, in, CYC_W: CPU run length, sampled on an accepted `i_Start`.
- `i_Instr_Valid`, in, 1: program word valid.
- `i_Instr_Data`, in, WORD_LEN: program word.
- `i_Instr_Last`, in, 1: marks the final program word.
- `o_Instr_Ready`, out, 1: program word accepted when high.
- `i_Gold_Valid`, in, 1: golden word valid.
- `i_Gold_Data`, in, WORD_LEN: golden word.
- `o_Gold_Ready`, out, 1: golden word accepted when high.
- `o_CPU_RSTN`, out, 1: CPU reset, active-low.
- `o_CPU_EN`, out, 1: CPU clock enable.
- `o_Instr_WE`, out, 1: instruction memory write strobe.
- `o_Instr_Addr`, out, IA_W: instruction memory write address.
- `o_Write_Instr`, out, WORD_LEN: instruction memory write data.
- `o_Reg_or_Data`, out, 1: scan source select; 1 = register file, 0 = data memory.
- `o_Test_Addr`, out, TA_W: scan address.
- `i_Test_Data`, in, WORD_LEN: CPU test port read data.
- `o_Busy`, out, 1: high in every state except IDLE and DONE.
- `o_Done`, out, 1: high in DONE.
- `o_Pass`, out, 1: valid while `o_Done` is high.
- `o_Err_Count`, out, ERR_W: number of mismatches, saturating.
- `o_First_Err_Addr`, out, TA_W: address of the first mismatch.
- `o_First_Err_Sel`, out, 1: `o_Reg_or_Data` value at the first mismatch.

## Operation
States and transitions:
- **IDLE:** on `i_Start`, clear counters and latches, capture `i_Run_Cycles`, go to LOAD.
- **LOAD:** `o_Instr_Ready` = 1.
  - Each handshake registers `o_Write_Instr` and `o_Instr_Addr`, pulses `o_Instr_WE` the next cycle, and increments the address.
  - A handshake with `i_Instr_Last`, or the write to address IMEM_DEPTH-1, ends LOAD.
  - Go to ZFILL if the address is below IMEM_DEPTH, otherwise to RUN.
  - `i_Instr_Last` on the final address goes straight to RUN.
- **ZFILL:** `o_Instr_Ready` = 0. Write 0 to every remaining address, one per cycle, up to IMEM_DEPTH-1, then go to RUN.
- **RUN:** `o_CPU_RSTN` = 1 and `o_CPU_EN` = 1 for exactly the captured cycle count. A count of 0 skips RUN. Then go to SCAN_REG.
- **SCAN_REG:** `o_CPU_EN` = 0, `o_CPU_RSTN` stays 1, `o_Reg_or_Data` = 1, addresses 0..REG_SIZE-1. Each entry takes two phases:
  - ADDR: address driven, ready 0, 1 cycle.
  - CMP: `o_Gold_Ready` = 1, held until a gold handshake.
  - On the handshake, compare `i_Test_Data` with `i_Gold_Data`. On mismatch, increment the error count (saturating at 2^ERR_W-1); on the first mismatch only, latch the address and sel. Then advance.
- **SCAN_MEM:** same as SCAN_REG with `o_Reg_or_Data` = 0, addresses 0..DMEM_DEPTH-1. Skipped when SCAN_DMEM = 0.
- **DONE:** `o_Done` = 1 and `o_Pass` = (error count == 0). Results hold until the next `i_Start`.

Rules:
- `o_CPU_RSTN` = 0 in IDLE, LOAD and ZFILL.
- `i_Start` while busy is ignored.
- An `i_Instr_Valid` beat outside LOAD is not accepted.
- An `i_Gold_Valid` beat outside a CMP phase is not accepted.

## Timing
- Reset values: all outputs 0 except `o_Reg_or_Data` = 1.
- Reset takes effect asynchronously from any state, including mid-LOAD or mid-SCAN. After reset release the block sits in IDLE with the CPU held in reset.
- `i_Start` accepted at edge n puts the block in LOAD, with `o_Instr_Ready` = 1, from cycle n+1.
- Instruction write latency: handshake at edge n gives `o_Instr_WE` high for cycle n+1. Accepted throughput is one word per cycle.
- ZFILL writes one word per cycle.
- RUN: `o_CPU_EN` is high for exactly N consecutive cycles.
- Scan throughput: 2 cycles per entry minimum; `o_Gold_Ready` stalls for as long as `i_Gold_Valid` is low.
- `i_Test_Data` is sampled at least 1 cycle after `o_Test_Addr` settles.
- DONE is reached 1 cycle after the last gold handshake.

## Test plan
- 34-word program with Last on word 34, IMEM_DEPTH = 64 → WE pulses at addresses 0..33 with the given data, then 30 zero writes at 34..63; `o_Instr_Ready` = 0 during ZFILL.
- `i_Run_Cycles` = 300 → `o_CPU_EN` high exactly 300 cycles; `o_CPU_RSTN` rises on the first RUN cycle and stays high.
- All 96 golden words match (REG_SIZE 32 + DMEM_DEPTH 64) → `o_Done` = 1, `o_Pass` = 1, `o_Err_Count` = 0; exactly 96 gold handshakes.
- Mismatches at register 5 and data address 10 → `o_Err_Count` = 2, `o_First_Err_Addr` = 5, `o_First_Err_Sel` = 1, `o_Pass` = 0.
- Random valid gaps on both streams plus `i_Start` pulses while busy → results identical to the gap-free run; the extra starts are ignored. With ERR_W = 4 and 20 mismatches → `o_Err_Count` = 15.
- Reset asserted mid-SCAN_MEM → all outputs at reset values immediately. A new `i_Start` afterwards runs to a clean pass.

Source files
------------

// File: rtl/cpu_test_ctrl.sv
// Test sequencer for the RISC-I CPU. It loads instruction memory, runs the CPU for a
// programmed number of cycles, then scans registers and data memory against a golden stream.
module cpu_test_ctrl #(
    parameter int WORD_LEN   = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int REG_SIZE   = 32,
    parameter int DMEM_DEPTH = 64,
    parameter int SCAN_DMEM  = 1,
    parameter int CYC_W      = 16,
    parameter int ERR_W      = 8,
    localparam int IA_W      = $clog2(IMEM_DEPTH),
    localparam int SCAN_MAX  = (REG_SIZE > DMEM_DEPTH) ? REG_SIZE : DMEM_DEPTH,
    localparam int TA_W      = $clog2(SCAN_MAX)
) (
    input  logic                i_CLK,
    input  logic                i_RSTN,
    input  logic                i_Start,
    input  logic [CYC_W-1:0]    i_Run_Cycles,
    input  logic                i_Instr_Valid,
    input  logic [WORD_LEN-1:0] i_Instr_Data,
    input  logic                i_Instr_Last,
    output logic                o_Instr_Ready,
    input  logic                i_Gold_Valid,
    input  logic [WORD_LEN-1:0] i_Gold_Data,
    output logic                o_Gold_Ready,
    output logic                o_CPU_RSTN,
    output logic                o_CPU_EN,
    output logic                o_Instr_WE,
    output logic [IA_W-1:0]     o_Instr_Addr,
    output logic [WORD_LEN-1:0] o_Write_Instr,
    output logic                o_Reg_or_Data,
    output logic [TA_W-1:0]     o_Test_Addr,
    input  logic [WORD_LEN-1:0] i_Test_Data,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Pass,
    output logic [ERR_W-1:0]    o_Err_Count,
    output logic [TA_W-1:0]     o_First_Err_Addr,
    output logic                o_First_Err_Sel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ZFILL = 3'd2,
        S_RUN   = 3'd3,
        S_SADDR = 3'd4,
        S_SCMP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [IA_W-1:0]  IA_ZERO     = {IA_W{1'b0}};
    localparam logic [IA_W-1:0]  IA_ONE      = IA_W'(1);
    localparam logic [IA_W-1:0]  IA_LAST     = IA_W'(IMEM_DEPTH - 1);
    localparam logic [TA_W-1:0]  TA_ZERO     = {TA_W{1'b0}};
    localparam logic [TA_W-1:0]  TA_ONE      = TA_W'(1);
    localparam logic [TA_W-1:0]  REG_LAST    = TA_W'(REG_SIZE - 1);
    localparam logic [TA_W-1:0]  MEM_LAST    = TA_W'(DMEM_DEPTH - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO    = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
    localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic             SCAN_MEM_EN = (SCAN_DMEM != 0);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        logic [ERR_W-1:0] result;
        if (value == {ERR_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + ERR_W'(1);
        end
        return result;
    endfunction

    state_t                state_r, state_nx_s;
    logic [IA_W-1:0]       addr_cnt_r, addr_cnt_nx_s;
    logic [CYC_W-1:0]      run_cnt_r, run_cnt_nx_s;
    logic                  sel_r, sel_nx_s;
    logic [TA_W-1:0]       test_addr_r, test_addr_nx_s;
    logic [ERR_W-1:0]      err_cnt_r, err_cnt_nx_s;
    logic [TA_W-1:0]       first_addr_r, first_addr_nx_s;
    logic                  first_sel_r, first_sel_nx_s;
    logic                  we_r, we_nx_s;
    logic [IA_W-1:0]       waddr_r, waddr_nx_s;
    logic [WORD_LEN-1:0]   wdata_r, wdata_nx_s;
    logic                  instr_ready_r, gold_ready_r, cpu_rstn_r, cpu_en_r;
    logic                  busy_r, done_r, pass_r;
    logic                  instr_hs_s, gold_hs_s, scan_last_s;
    state_t                after_load_s;

    // Next-state and datapath updates for the whole sequence
    always_comb begin
        state_nx_s      = state_r;
        addr_cnt_nx_s   = addr_cnt_r;
        run_cnt_nx_s    = run_cnt_r;
        sel_nx_s        = sel_r;
        test_addr_nx_s  = test_addr_r;
        err_cnt_nx_s    = err_cnt_r;
        first_addr_nx_s = first_addr_r;
        first_sel_nx_s  = first_sel_r;
        we_nx_s         = 1'b0;
        waddr_nx_s      = waddr_r;
        wdata_nx_s      = wdata_r;
        instr_hs_s      = instr_ready_r & i_Instr_Valid;
        gold_hs_s       = gold_ready_r & i_Gold_Valid;
        scan_last_s     = sel_r ? (test_addr_r == REG_LAST) : (test_addr_r == MEM_LAST);
        // A zero run length goes straight from loading to the register scan
        after_load_s    = (run_cnt_r == CYC_ZERO) ? S_SADDR : S_RUN;

        case (state_r)
            S_IDLE, S_DONE: begin
                if (i_Start) begin
                    state_nx_s      = S_LOAD;
                    addr_cnt_nx_s   = IA_ZERO;
                    run_cnt_nx_s    = i_Run_Cycles;
                    sel_nx_s        = 1'b1;
                    test_addr_nx_s  = TA_ZERO;
                    err_cnt_nx_s    = ERR_ZERO;
                    first_addr_nx_s = TA_ZERO;
                    first_sel_nx_s  = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_LOAD: begin
                if (instr_hs_s) begin
                    we_nx_s       = 1'b1;
                    waddr_nx_s    = addr_cnt_r;
                    wdata_nx_s    = i_Instr_Data;
                    addr_cnt_nx_s = addr_cnt_r + IA_ONE;
                    if (addr_cnt_r == IA_LAST) begin
                        state_nx_s = after_load_s;
                    end else if (i_Instr_Last) begin
                        state_nx_s = S_ZFILL;
                    end else begin
                        state_nx_s = S_LOAD;
                    end
                end else begin
                    state_nx_s = S_LOAD;
                end
            end
            S_ZFILL: begin
                we_nx_s       = 1'b1;
                waddr_nx_s    = addr_cnt_r;
                wdata_nx_s    = {WORD_LEN{1'b0}};
                addr_cnt_nx_s = addr_cnt_r + IA_ONE;
                if (addr_cnt_r == IA_LAST) begin
                    state_nx_s = after_load_s;
                end else begin
                    state_nx_s = S_ZFILL;
                end
            end
            S_RUN: begin
                run_cnt_nx_s = run_cnt_r - CYC_ONE;
                if (run_cnt_r <= CYC_ONE) begin
                    state_nx_s = S_SADDR;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_SADDR: begin
                state_nx_s = S_SCMP;
            end
            S_SCMP: begin
                if (gold_hs_s) begin
                    if (i_Test_Data != i_Gold_Data) begin
                        err_cnt_nx_s = sat_inc(err_cnt_r);
                        if (err_cnt_r == ERR_ZERO) begin
                            first_addr_nx_s = test_addr_r;
                            first_sel_nx_s  = sel_r;
                        end else begin
                            first_addr_nx_s = first_addr_r;
                        end
                    end else begin
                        err_cnt_nx_s = err_cnt_r;
                    end
                    if (!scan_last_s) begin
                        test_addr_nx_s = test_addr_r + TA_ONE;
                        state_nx_s     = S_SADDR;
                    end else if (sel_r && SCAN_MEM_EN) begin
                        sel_nx_s       = 1'b0;
                        test_addr_nx_s = TA_ZERO;
                        state_nx_s     = S_SADDR;
                    end else begin
                        state_nx_s = S_DONE;
                    end
                end else begin
                    state_nx_s = S_SCMP;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and outputs, all registered from the next-state values
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_r       <= S_IDLE;
            addr_cnt_r    <= IA_ZERO;
            run_cnt_r     <= CYC_ZERO;
            sel_r         <= 1'b1;
            test_addr_r   <= TA_ZERO;
            err_cnt_r     <= ERR_ZERO;
            first_addr_r  <= TA_ZERO;
            first_sel_r   <= 1'b0;
            we_r          <= 1'b0;
            waddr_r       <= IA_ZERO;
            wdata_r       <= {WORD_LEN{1'b0}};
            instr_ready_r <= 1'b0;
            gold_ready_r  <= 1'b0;
            cpu_rstn_r    <= 1'b0;
            cpu_en_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            addr_cnt_r    <= addr_cnt_nx_s;
            run_cnt_r     <= run_cnt_nx_s;
            sel_r         <= sel_nx_s;
            test_addr_r   <= test_addr_nx_s;
            err_cnt_r     <= err_cnt_nx_s;
            first_addr_r  <= first_addr_nx_s;
            first_sel_r   <= first_sel_nx_s;
            we_r          <= we_nx_s;
            waddr_r       <= waddr_nx_s;
            wdata_r       <= wdata_nx_s;
            instr_ready_r <= (state_nx_s == S_LOAD);
            gold_ready_r  <= (state_nx_s == S_SCMP);
            cpu_rstn_r    <= !(state_nx_s inside {S_IDLE, S_LOAD, S_ZFILL});
            cpu_en_r      <= (state_nx_s == S_RUN);
            busy_r        <= !(state_nx_s inside {S_IDLE, S_DONE});
            done_r        <= (state_nx_s == S_DONE);
            pass_r        <= (state_nx_s == S_DONE) && (err_cnt_nx_s == ERR_ZERO);
        end
    end

    assign o_Instr_Ready    = instr_ready_r;
    assign o_Gold_Ready     = gold_ready_r;
    assign o_CPU_RSTN       = cpu_rstn_r;
    assign o_CPU_EN         = cpu_en_r;
    assign o_Instr_WE       = we_r;
    assign o_Instr_Addr     = waddr_r;
    assign o_Write_Instr    = wdata_r;
    assign o_Reg_or_Data    = sel_r;
    assign o_Test_Addr      = test_addr_r;
    assign o_Busy           = busy_r;
    assign o_Done           = done_r;
    assign o_Pass           = pass_r;
    assign o_Err_Count      = err_cnt_r;
    assign o_First_Err_Addr = first_addr_r;
    assign o_First_Err_Sel  = first_sel_r;

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Scoreboard bench for cpu_test_ctrl: directed programs and golden streams with hand-picked
// mismatches; a monitor process checks memory writes, run length, scan order and results.
module tb_cpu_test_ctrl;
    localparam int IMEM_DEPTH = 64;
    localparam int CYC_W      = 16;
    localparam int ERR_W      = 4;
    localparam int IA_W       = 6;
    localparam int TA_W       = 6;
    localparam int NSCAN      = 96;

    logic              i_CLK = 1'b0, i_RSTN = 1'b0, i_Start = 1'b0;
    logic [CYC_W-1:0]  i_Run_Cycles = '0;
    logic              i_Instr_Valid = 1'b0, i_Instr_Last = 1'b0, i_Gold_Valid = 1'b0;
    logic [31:0]       i_Instr_Data = '0, i_Gold_Data = '0, i_Test_Data;
    logic              o_Instr_Ready, o_Gold_Ready, o_CPU_RSTN, o_CPU_EN, o_Instr_WE;
    logic [IA_W-1:0]   o_Instr_Addr;
    logic [31:0]       o_Write_Instr;
    logic              o_Reg_or_Data, o_Busy, o_Done, o_Pass, o_First_Err_Sel;
    logic [TA_W-1:0]   o_Test_Addr, o_First_Err_Addr;
    logic [ERR_W-1:0]  o_Err_Count;

    cpu_test_ctrl #(.ERR_W(ERR_W)) dut (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN), .i_Start(i_Start), .i_Run_Cycles(i_Run_Cycles),
        .i_Instr_Valid(i_Instr_Valid), .i_Instr_Data(i_Instr_Data), .i_Instr_Last(i_Instr_Last),
        .o_Instr_Ready(o_Instr_Ready), .i_Gold_Valid(i_Gold_Valid), .i_Gold_Data(i_Gold_Data),
        .o_Gold_Ready(o_Gold_Ready), .o_CPU_RSTN(o_CPU_RSTN), .o_CPU_EN(o_CPU_EN),
        .o_Instr_WE(o_Instr_WE), .o_Instr_Addr(o_Instr_Addr), .o_Write_Instr(o_Write_Instr),
        .o_Reg_or_Data(o_Reg_or_Data), .o_Test_Addr(o_Test_Addr), .i_Test_Data(i_Test_Data),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Pass(o_Pass), .o_Err_Count(o_Err_Count),
        .o_First_Err_Addr(o_First_Err_Addr), .o_First_Err_Sel(o_First_Err_Sel)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct { int addr; logic [31:0] data; bit zf; } wr_t;
    typedef struct { bit pass; int err; int faddr; bit fsel; int ncyc; int nseg; } res_t;

    wr_t  wq[$];
    res_t rq[$];
    int   n_checks = 0, n_fail = 0;
    int   en_cnt = 0, en_seg = 0, gold_cnt = 0;
    bit   en_prev = 1'b0, rstn_prev = 1'b0, done_prev = 1'b0, abort = 1'b0;

    // Stand-in for the CPU test port: register file and data memory contents
    function automatic logic [31:0] cpu_word(input logic sel, input int addr);
        return sel ? (32'hA5A5_0000 | 32'(addr)) : (32'h5A5A_0000 | 32'(addr));
    endfunction

    function automatic logic [31:0] gold_word(input int k);
        return (k < 32) ? cpu_word(1'b1, k) : cpu_word(1'b0, k - 32);
    endfunction

    function automatic logic [31:0] prog_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    function automatic res_t mk_res(input bit pass, input int err, input int faddr,
                                    input bit fsel, input int ncyc, input int nseg);
        res_t r;
        r.pass = pass; r.err = err; r.faddr = faddr; r.fsel = fsel; r.ncyc = ncyc; r.nseg = nseg;
        return r;
    endfunction

    assign i_Test_Data = cpu_word(o_Reg_or_Data, int'(o_Test_Addr));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic monitor();
        wr_t  w;
        res_t r;
        forever begin
            @(negedge i_CLK);
            if (i_RSTN) begin
                if (o_Instr_WE) begin
                    if (wq.size() == 0) begin
                        fail_now("unexpected_we");
                    end else begin
                        w = wq.pop_front();
                        check("we_addr", 64'(o_Instr_Addr), 64'(w.addr));
                        check("we_data", 64'(o_Write_Instr), 64'(w.data));
                        if (w.zf) check("zfill_ready", 64'(o_Instr_Ready), 64'd0);
                    end
                end
                if (o_CPU_EN) begin
                    en_cnt++;
                    if (!en_prev) begin
                        en_seg++;
                        check("rstn_rise", 64'({rstn_prev, o_CPU_RSTN}), 64'd1);
                    end
                end
                if (o_Gold_Ready && i_Gold_Valid) begin
                    check("scan_sel", 64'(o_Reg_or_Data), 64'(gold_cnt < 32));
                    check("scan_addr", 64'(o_Test_Addr), 64'((gold_cnt < 32) ? gold_cnt : gold_cnt - 32));
                    check("scan_cpu", 64'({o_CPU_RSTN, o_CPU_EN}), 64'd2);
                    gold_cnt++;
                end
                if (o_Done && !done_prev) begin
                    if (rq.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        r = rq.pop_front();
                        check("pass", 64'(o_Pass), 64'(r.pass));
                        check("err_count", 64'(o_Err_Count), 64'(r.err));
                        check("first_addr", 64'(o_First_Err_Addr), 64'(r.faddr));
                        check("first_sel", 64'(o_First_Err_Sel), 64'(r.fsel));
                        check("run_cycles", 64'(en_cnt), 64'(r.ncyc));
                        check("run_segments", 64'(en_seg), 64'(r.nseg));
                        check("gold_beats", 64'(gold_cnt), 64'(NSCAN));
                        check("writes_left", 64'(wq.size()), 64'd0);
                        check("busy_in_done", 64'(o_Busy), 64'd0);
                    end
                end
            end
            en_prev   = o_CPU_EN;
            rstn_prev = o_CPU_RSTN;
            done_prev = o_Done;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({o_Instr_Ready, o_Gold_Ready, o_CPU_RSTN, o_CPU_EN, o_Instr_WE,
                                  o_Busy, o_Done, o_Pass, o_First_Err_Sel}), 64'd0);
        check({tag, "_sel"}, 64'(o_Reg_or_Data), 64'd1);
        check({tag, "_addrs"}, 64'({o_Instr_Addr, o_Test_Addr, o_First_Err_Addr}), 64'd0);
        check({tag, "_wdata"}, 64'(o_Write_Instr), 64'd0);
        check({tag, "_errs"}, 64'(o_Err_Count), 64'd0);
    endtask

    task automatic start_run(input int nprog, input int ncyc, input bit push, input res_t r);
        wr_t w;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            w.addr = i;
            w.data = (i < nprog) ? prog_word(i) : 32'h0;
            w.zf   = (i >= nprog);
            wq.push_back(w);
        end
        if (push) rq.push_back(r);
        en_cnt = 0; en_seg = 0; gold_cnt = 0;
        i_Run_Cycles = CYC_W'(ncyc);
        i_Start = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
        check("load_after_start", 64'({o_Instr_Ready, o_Busy, o_CPU_RSTN}), 64'd6);
    endtask

    task automatic send_prog(input int nprog, input bit gaps);
        int guard;
        for (int i = 0; i < nprog; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_Instr_Valid = 1'b0;
                @(negedge i_CLK);
            end
            i_Instr_Valid = 1'b1;
            i_Instr_Data  = prog_word(i);
            i_Instr_Last  = (i == nprog - 1);
            guard = 0;
            while (!o_Instr_Ready && guard < 200) begin
                @(negedge i_CLK);
                guard++;
            end
            if (guard >= 200) begin
                fail_now("prog_timeout");
                break;
            end
            @(negedge i_CLK);
        end
        i_Instr_Valid = 1'b0;
        i_Instr_Last  = 1'b0;
    endtask

    task automatic send_gold(input logic [NSCAN-1:0] mask, input bit gaps);
        int guard;
        for (int k = 0; k < NSCAN && !abort; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_Gold_Valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge i_CLK);
            end
            i_Gold_Valid = 1'b1;
            i_Gold_Data  = gold_word(k) ^ {31'd0, mask[k]};
            guard = 0;
            while (!o_Gold_Ready && !abort && guard < 2000) begin
                @(negedge i_CLK);
                guard++;
            end
            if (guard >= 2000) begin
                fail_now("gold_timeout");
                break;
            end
            @(negedge i_CLK);
        end
        i_Gold_Valid = 1'b0;
    endtask

    task automatic poke_starts();
        for (int p = 0; p < 3; p++) begin
            repeat ((p == 0) ? 40 : 200) @(negedge i_CLK);
            i_Start = 1'b1;
            @(negedge i_CLK);
            i_Start = 1'b0;
        end
    endtask

    task automatic run_test(input int nprog, input int ncyc, input logic [NSCAN-1:0] mask,
                            input bit gaps, input res_t r);
        int guard;
        start_run(nprog, ncyc, 1'b1, r);
        fork
            send_prog(nprog, gaps);
            send_gold(mask, gaps);
            if (gaps) poke_starts();
        join
        check("done_latency", 64'(o_Done), 64'd1);
        guard = 0;
        while (!o_Done && guard < 100) begin
            @(negedge i_CLK);
            guard++;
        end
        if (guard >= 100) fail_now("done_timeout");
        @(negedge i_CLK);
    endtask

    initial begin
        logic [NSCAN-1:0] m_none, m_two, m_many;
        int guard;
        m_none = '0;
        m_two  = '0;
        m_two[5]  = 1'b1;
        m_two[42] = 1'b1;
        m_many = '0;
        for (int k = 52; k < 72; k++) m_many[k] = 1'b1;

        fork
            monitor();
        join_none

        repeat (3) @(negedge i_CLK);
        check_reset("reset");
        i_RSTN = 1'b1;
        repeat (2) @(negedge i_CLK);
        check_reset("idle");

        run_test(34, 300, m_none, 1'b0, mk_res(1'b1, 0, 0, 1'b0, 300, 1));
        run_test(34, 5, m_two, 1'b0, mk_res(1'b0, 2, 5, 1'b1, 5, 1));
        run_test(10, 1, m_many, 1'b0, mk_res(1'b0, 15, 20, 1'b0, 1, 1));
        run_test(34, 300, m_two, 1'b1, mk_res(1'b0, 2, 5, 1'b1, 300, 1));
        run_test(64, 0, m_none, 1'b0, mk_res(1'b1, 0, 0, 1'b0, 0, 0));

        // Reset in the middle of the data-memory scan
        start_run(34, 3, 1'b0, mk_res(1'b1, 0, 0, 1'b0, 3, 1));
        fork
            send_prog(34, 1'b0);
            send_gold(m_none, 1'b0);
            begin
                guard = 0;
                while (!(o_Gold_Ready && !o_Reg_or_Data && o_Test_Addr == 6'd7) && guard < 1000) begin
                    @(negedge i_CLK);
                    guard++;
                end
                if (guard >= 1000) fail_now("reach_scan_mem");
                #2 i_RSTN = 1'b0;
                #1 check_reset("mid_scan");
                abort = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (2) @(negedge i_CLK);
        i_RSTN = 1'b1;
        repeat (2) @(negedge i_CLK);
        check_reset("post_release");

        run_test(34, 300, m_none, 1'b0, mk_res(1'b1, 0, 0, 1'b0, 300, 1));

        repeat (3) @(negedge i_CLK);
        check("results_left", 64'(rq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
